// File: rtl/spi_reg_ctrl.sv
// Frame-level SPI controller: decodes {rw, addr} command bytes into auto-incrementing
// register bus bursts and stages read data on tx_data for the byte-wide slave.
module spi_reg_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 7,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           MAX_BURST  = 16,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_active,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  tx_req,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_WR_DATA  = 3'd2;
    localparam logic [2:0] S_RD_FETCH = 3'd3;
    localparam logic [2:0] S_RD_LOAD  = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;

    logic [2:0]            state_q, state_d;
    logic                  cs_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        tx_d    = tx_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        // Write address advances the cycle after its strobe, so it lines up with the strobe.
        if (wr_q) addr_d = addr_q + ADDR_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                tx_d = IDLE_BYTE;
                if (cs_active && !cs_q) state_d = S_CMD;
            end
            S_CMD: begin
                if (!cs_active) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (rx_valid) begin
                    addr_d = rx_data[ADDR_WIDTH-1:0];
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    if (rx_data[DATA_WIDTH-1]) begin
                        state_d = S_RD_FETCH;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: begin
                if (!cs_active) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    if (cnt_q == CNT_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        wdata_d = rx_data;
                        wr_d    = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RD_FETCH: begin
                if (!cs_active) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tx_d    = IDLE_BYTE;
                end else begin
                    state_d = S_RD_LOAD;
                end
            end
            S_RD_LOAD: begin
                // The read issued in RD_FETCH is discarded if the frame was dropped.
                if (!cs_active) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tx_d    = IDLE_BYTE;
                end else begin
                    tx_d    = reg_rdata;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (!cs_active) begin
                    state_d = S_IDLE;
                    tx_d    = IDLE_BYTE;
                end else if (tx_req) begin
                    if (cnt_q == CNT_MAX) begin
                        err_d = 1'b1;
                        tx_d  = IDLE_BYTE;
                    end else begin
                        state_d = S_RD_FETCH;
                        rd_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cs_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            tx_q    <= IDLE_BYTE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_active;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_data   = tx_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = wr_q;
    assign reg_rd    = rd_q;
    assign frame_err = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized bench for spi_reg_ctrl: a register-bus memory model plus a burst reference
// (address a+i mod 128, at most 16 data bytes per frame) checks every frame.
module tb_spi_reg_ctrl;

    localparam int MB = 16;
    localparam logic [7:0] IDLE = 8'hA5;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cs_active = 1'b0, rx_valid = 1'b0, tx_req = 1'b0;
    logic [7:0] rx_data = '0, reg_rdata = '0;
    logic [7:0] tx_data, reg_wdata;
    logic [6:0] reg_addr;
    logic       reg_wr, reg_rd, frame_err, busy;

    int vecs = 0, errs = 0, both_cnt = 0;
    logic [7:0] mem [128];
    logic [6:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [6:0] rd_addr_q[$];

    always #5 clk = ~clk;

    spi_reg_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .MAX_BURST(MB), .IDLE_BYTE(IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_req(tx_req), .tx_data(tx_data), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
        .frame_err(frame_err), .busy(busy)
    );

    // Register bank: read data valid exactly one cycle after reg_rd, garbage otherwise.
    always @(posedge clk) reg_rdata <= reg_rd ? mem[reg_addr] : 8'($urandom);

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (reg_rd) rd_addr_q.push_back(reg_addr);
        if (reg_wr && reg_rd) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Driver tasks: all entered and left on a negedge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start;
        cs_active = 1'b1;
        cyc(2);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    endtask

    task automatic frame_end;
        cs_active = 1'b0;
        cyc(3);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        cyc(gap);
    endtask

    task automatic req(input bit with_rx);
        tx_req = 1'b1;
        if (with_rx) begin rx_data = 8'($urandom); rx_valid = 1'b1; end
        @(negedge clk);
        tx_req = 1'b0; rx_valid = 1'b0;
        cyc(4);
    endtask

    task automatic run_write(input logic [6:0] a, input logic [7:0] d[$], input int gap);
        frame_start();
        send({1'b0, a}, 2);
        foreach (d[i]) send(d[i], (gap < 0) ? int'($urandom_range(1, 4)) : gap);
        cyc(2);
    endtask

    task automatic test_reset;
        #1;
        vecs++; if (tx_data !== IDLE) $display("FAIL reset_tx: got %h want %h", tx_data, IDLE);
        vecs++; if (reg_addr !== 7'h0 || reg_wdata !== 8'h0) $display("FAIL reset_bus: addr %h wdata %h want 0", reg_addr, reg_wdata);
        vecs++; if ({reg_wr, reg_rd, frame_err, busy} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {reg_wr, reg_rd, frame_err, busy});
        if (tx_data !== IDLE || reg_addr !== 7'h0 || reg_wdata !== 8'h0 || {reg_wr, reg_rd, frame_err, busy} !== 4'b0) errs++;
        @(negedge clk); rst_n = 1'b1; cyc(2);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_burst;
        for (int f = 0; f < 5; f++) begin
            logic [6:0] a;
            logic [7:0] d[$];
            if (f == 0) begin
                a = 7'h05; d = '{8'h11, 8'h22, 8'h33};
            end else begin
                a = 7'($urandom);
                repeat ($urandom_range(1, 6)) d.push_back(8'($urandom));
            end
            run_write(a, d, -1);
            vecs++; if (wr_addr_q.size() != d.size() || rd_addr_q.size() != 0) begin
                errs++; $display("FAIL wr_count: got %0d wr %0d rd want %0d wr 0 rd", wr_addr_q.size(), rd_addr_q.size(), d.size());
            end
            for (int i = 0; i < d.size() && i < wr_addr_q.size(); i++) begin
                vecs++; if (wr_addr_q[i] !== 7'((int'(a) + i) % 128) || wr_data_q[i] !== d[i]) begin
                    errs++; $display("FAIL wr_beat%0d: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 7'((int'(a) + i) % 128), d[i]);
                end
            end
            vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL wr_err: got %b want 0", frame_err); end
            frame_end();
            vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL wr_idle_busy: got %b want 0", busy); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d[$];
        logic [6:0] a;
        a = 7'($urandom);
        repeat (5) d.push_back(8'($urandom));
        run_write(a, d, 0);
        vecs++; if (wr_addr_q.size() != 5) begin errs++; $display("FAIL b2b_count: got %0d want 5", wr_addr_q.size()); end
        for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
            vecs++; if (wr_addr_q[i] !== 7'((int'(a) + i) % 128) || wr_data_q[i] !== d[i]) begin
                errs++; $display("FAIL b2b_beat%0d: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 7'((int'(a) + i) % 128), d[i]);
            end
        end
        frame_end();
    endtask

    task automatic test_read_burst;
        logic [6:0] a;
        logic [7:0] exp;
        int k;
        mem[16] = 8'hDE; mem[17] = 8'hAD;
        frame_start();
        rx_data = 8'h90; rx_valid = 1'b1;
        @(posedge clk); @(negedge clk); rx_valid = 1'b0;
        @(posedge clk); #1;
        vecs++; if (tx_data !== IDLE) begin errs++; $display("FAIL rd_early: got %h want %h", tx_data, IDLE); end
        @(posedge clk); #1;
        vecs++; if (tx_data !== 8'hDE) begin errs++; $display("FAIL rd_first: got %h want de", tx_data); end
        @(negedge clk);
        req(1'b0);
        vecs++; if (tx_data !== 8'hAD) begin errs++; $display("FAIL rd_second: got %h want ad", tx_data); end
        vecs++; if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 7'h10 || rd_addr_q[1] !== 7'h11) begin
            errs++; $display("FAIL rd_addrs: got %0d reads want 2 at 10,11", rd_addr_q.size());
        end
        frame_end();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
            a = 7'($urandom);
            k = $urandom_range(1, 5);
            frame_start();
            send({1'b1, a}, 3);
            vecs++; if (tx_data !== mem[a]) begin errs++; $display("FAIL rdr_load0: got %h want %h", tx_data, mem[a]); end
            send(8'($urandom), 2);
            vecs++; if (tx_data !== mem[a]) begin errs++; $display("FAIL rdr_dummy: got %h want %h", tx_data, mem[a]); end
            for (int j = 1; j <= k; j++) begin
                req(j[0]);
                exp = mem[(int'(a) + j) % 128];
                vecs++; if (tx_data !== exp) begin errs++; $display("FAIL rdr_byte%0d: got %h want %h", j, tx_data, exp); end
            end
            vecs++; if (rd_addr_q.size() != k + 1 || wr_addr_q.size() != 0 || frame_err !== 1'b0) begin
                errs++; $display("FAIL rdr_strobes: got %0d rd %0d wr err %b want %0d rd 0 wr err 0", rd_addr_q.size(), wr_addr_q.size(), frame_err, k + 1);
            end
            for (int j = 0; j <= k && j < rd_addr_q.size(); j++) begin
                vecs++; if (rd_addr_q[j] !== 7'((int'(a) + j) % 128)) begin
                    errs++; $display("FAIL rdr_addr%0d: got %h want %h", j, rd_addr_q[j], 7'((int'(a) + j) % 128));
                end
            end
            frame_end();
            vecs++; if (busy !== 1'b0 || tx_data !== IDLE) begin errs++; $display("FAIL rdr_idle: busy %b tx %h want 0/a5", busy, tx_data); end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] d[$];
        d = '{8'hAA, 8'hBB};
        run_write(7'h7F, d, -1);
        vecs++; if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 7'h7F || wr_addr_q[1] !== 7'h00 || wr_data_q[1] !== 8'hBB) begin
            errs++; $display("FAIL wrap: got %0d writes want 7f:aa 00:bb", wr_addr_q.size());
        end
        vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL wrap_err: got %b want 0", frame_err); end
        frame_end();
    endtask

    task automatic test_overflow;
        logic [7:0] d[$];
        logic [6:0] a;
        logic [7:0] exp;
        repeat (MB + 1) d.push_back(8'($urandom));
        run_write(7'h00, d, -1);
        vecs++; if (wr_addr_q.size() != MB) begin errs++; $display("FAIL ovf_count: got %0d want %0d", wr_addr_q.size(), MB); end
        for (int i = 0; i < MB && i < wr_addr_q.size(); i++) begin
            vecs++; if (wr_addr_q[i] !== 7'(i) || wr_data_q[i] !== d[i]) begin
                errs++; $display("FAIL ovf_beat%0d: got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], 7'(i), d[i]);
            end
        end
        vecs++; if (frame_err !== 1'b1) begin errs++; $display("FAIL ovf_err: got %b want 1", frame_err); end
        frame_end();
        vecs++; if (frame_err !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", frame_err); end
        frame_start();
        send(8'h03, 2);
        vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b want 0", frame_err); end
        frame_end();
        // Read side: sixteen bytes, then idle filler.
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        a = 7'($urandom);
        frame_start();
        send({1'b1, a}, 3);
        for (int j = 1; j <= MB; j++) begin
            req(1'b0);
            exp = (j < MB) ? mem[(int'(a) + j) % 128] : IDLE;
            vecs++; if (tx_data !== exp) begin errs++; $display("FAIL rovf_byte%0d: got %h want %h", j, tx_data, exp); end
        end
        vecs++; if (rd_addr_q.size() != MB || frame_err !== 1'b1) begin
            errs++; $display("FAIL rovf_flags: got %0d reads err %b want %0d err 1", rd_addr_q.size(), frame_err, MB);
        end
        frame_end();
    endtask

    task automatic test_abort;
        logic [7:0] d[$];
        d = '{8'h5A};
        run_write(7'h33, d, -1);
        frame_end();
        vecs++; if (frame_err !== 1'b0 || wr_addr_q.size() != 1) begin
            errs++; $display("FAIL abort_wr: err %b writes %0d want 0/1", frame_err, wr_addr_q.size());
        end
        frame_start();
        rx_data = {1'b1, 7'($urandom)}; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; cs_active = 1'b0;
        cyc(4);
        vecs++; if (busy !== 1'b0 || tx_data !== IDLE || frame_err !== 1'b1) begin
            errs++; $display("FAIL abort_rd: busy %b tx %h err %b want 0/a5/1", busy, tx_data, frame_err);
        end
        vecs++; if (rd_addr_q.size() != 1) begin errs++; $display("FAIL abort_rd_count: got %0d want 1", rd_addr_q.size()); end
        frame_start();
        send(8'h01, 2);
        frame_end();
        vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL abort_clear: got %b want 0", frame_err); end
        frame_start();
        frame_end();
        vecs++; if (frame_err !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL abort_cmd: err %b busy %b want 1/0", frame_err, busy); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d[$];
        frame_start();
        send(8'h40, 2);
        rx_data = 8'h77; rx_valid = 1'b1;
        @(posedge clk); #1;
        vecs++; if (reg_wr !== 1'b1 || reg_addr !== 7'h40 || reg_wdata !== 8'h77) begin
            errs++; $display("FAIL mid_pre: wr %b addr %h wdata %h want 1/40/77", reg_wr, reg_addr, reg_wdata);
        end
        rst_n = 1'b0; #1;
        vecs++; if ({reg_wr, reg_rd, frame_err, busy} !== 4'b0 || reg_addr !== 7'h0 || reg_wdata !== 8'h0 || tx_data !== IDLE) begin
            errs++; $display("FAIL mid_reset: flags %b addr %h wdata %h tx %h want 0000/00/00/a5", {reg_wr, reg_rd, frame_err, busy}, reg_addr, reg_wdata, tx_data);
        end
        @(negedge clk); rx_valid = 1'b0; cs_active = 1'b0;
        cyc(2); rst_n = 1'b1; cyc(2);
        d = '{8'hC3, 8'h3C};
        run_write(7'h21, d, -1);
        vecs++; if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 7'h21 || wr_data_q[0] !== 8'hC3 || wr_addr_q[1] !== 7'h22 || wr_data_q[1] !== 8'h3C) begin
            errs++; $display("FAIL mid_after: got %0d writes want 21:c3 22:3c", wr_addr_q.size());
        end
        frame_end();
    endtask

    task automatic test_strobe_exclusive;
        vecs++; if (both_cnt != 0) begin errs++; $display("FAIL strobe_excl: got %0d overlapping cycles want 0", both_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        @(posedge clk);
        test_reset();
        test_write_burst();
        test_back_to_back();
        test_read_burst();
        test_wrap();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_strobe_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Frame-level controller between the byte-wide SPI slave and the CORDIC register bank. It decodes a command byte into a read or write with an address. It sequences auto-incrementing burst accesses on a simple register bus and stages read data on tx_data for the slave to shift out. It also tracks frame state and flags aborted or overflowed frames.

Parameters:
ADDR_WIDTH, 7, register address width; command byte is {rw, addr[ADDR_WIDTH-1:0]}, so DATA_WIDTH = ADDR_WIDTH+1.
DATA_WIDTH, 8, SPI byte width; must equal ADDR_WIDTH+1.
MAX_BURST, 16, maximum data bytes per frame before overflow.
IDLE_BYTE, 8'hA5, value driven on tx_data outside read data phase.

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
cs_active  in  1  synchronized chip-select active (high = frame in progress)
rx_data  in  DATA_WIDTH  byte from SPI slave
rx_valid  in  1  1-cycle pulse, rx_data valid
tx_req  in  1  1-cycle pulse, slave finished shifting current tx byte
tx_data  out  DATA_WIDTH  byte to SPI slave
reg_addr  out  ADDR_WIDTH  register bus address
reg_wdata  out  DATA_WIDTH  register write data
reg_wr  out  1  1-cycle write strobe
reg_rd  out  1  1-cycle read strobe
reg_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after reg_rd
frame_err  out  1  sticky: frame aborted or overflowed; cleared by next frame's command byte
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, tx_data=IDLE_BYTE, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, frame_err=0, busy=0, byte counter=0.
- States: IDLE, CMD, WR_DATA, RD_FETCH, RD_LOAD, RD_DATA.
- IDLE: cs_active rising -> CMD on the next cycle. tx_data=IDLE_BYTE.
- CMD: wait for rx_valid.
  - Latch reg_addr=rx_data[ADDR_WIDTH-1:0], clear frame_err, byte counter=0.
  - rx_data[MSB]=0 -> WR_DATA.
  - rx_data[MSB]=1 -> RD_FETCH.
- WR_DATA: on each rx_valid:
  - reg_wdata=rx_data; reg_wr=1 the following cycle, with reg_addr equal to the current address.
  - Address increments the cycle after reg_wr.
  - tx_req ignored.
- RD_FETCH: reg_rd=1 for one cycle at reg_addr -> RD_LOAD.
- RD_LOAD: tx_data=reg_rdata, address++, counter++ -> RD_DATA. tx_data is valid 2 cycles after the command-byte rx_valid.
- RD_DATA:
  - On tx_req -> RD_FETCH, prefetching the next byte.
  - rx_valid bytes (dummy MOSI) are ignored.
- Address wraps from 2^ADDR_WIDTH-1 to 0 without error.
- Overflow: a data byte arriving when the counter already equals MAX_BURST:
  - Write: the write is suppressed.
  - Read: no fetch; tx_data=IDLE_BYTE.
  - frame_err=1; remain in the data state until cs drops.
- cs_active low in any non-IDLE state -> IDLE next cycle.
  - If dropped in CMD with zero bytes, or in RD_FETCH/RD_LOAD, frame_err=1.
  - A pending reg_wr already scheduled still completes (1 cycle); no new strobes are issued.
  - A pending reg_rd completes, but its data is discarded and tx_data=IDLE_BYTE.
- Simultaneous rx_valid and cs_active falling: the cs drop wins and the byte is discarded.
- Simultaneous rx_valid and tx_req in RD_DATA: tx_req is honored and rx_valid is ignored.
- reg_wr and reg_rd are never asserted together; each is high at most 1 cycle per byte.
- busy = (state != IDLE).

Test Plan:
- Write burst: cs, cmd 8'h05, data 8'h11, 8'h22, 8'h33 -> reg_wr pulses at addr 5, 6, 7 with wdata 11, 22, 33; frame_err=0.
- Read burst: regs 0x10=0xDE, 0x11=0xAD; cmd 8'h90, 2 tx_req -> reg_rd at 0x10 then 0x11; tx_data=DE two cycles after cmd rx_valid, then AD after the first tx_req.
- Wrap: cmd 8'h7F, 2 data bytes AA, BB -> writes at 0x7F then 0x00, no error.
- Overflow: write burst of MAX_BURST+1=17 bytes from addr 0 -> 16 reg_wr pulses, 17th suppressed, frame_err=1; next frame's cmd byte clears it.
- Abort: cs drops 1 cycle after read-cmd rx_valid -> state IDLE, tx_data=A5, frame_err=1, no extra reg_rd.
- Reset mid-burst: assert rst_n low during WR_DATA -> all outputs return to reset values immediately; the next frame operates normally.
